// File: rtl/multimode_ff_bank_pkg.sv
// ff_pkg: mode encoding and SR-conflict policy constants for the flip-flop bank
package ff_pkg;
  typedef enum logic [1:0] {MODE_SR = 2'b00, MODE_JK = 2'b01, MODE_D = 2'b10, MODE_T = 2'b11} mode_e;
  localparam int POL_HOLD  = 0;
  localparam int POL_SET   = 1;
  localparam int POL_RESET = 2;
endpackage

// File: rtl/multimode_ff_bank_if.sv
// multimode_ff_bank_if: control, operand and status bundle for the flip-flop bank
interface multimode_ff_bank_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             err;
  logic [CNT_W-1:0] conflict_cnt;
  modport master (output en, mode, a, b, clr_err, input q, qbar, err, conflict_cnt);
  modport slave  (input en, mode, a, b, clr_err, output q, qbar, err, conflict_cnt);
endinterface

// File: rtl/multimode_ff_bank_ff_cell.sv
// ff_cell: one SR/JK/D/T channel, next-state logic plus its state register
module ff_cell
  import ff_pkg::*;
#(
  parameter int   SR_POLICY = POL_HOLD,
  parameter logic RST_BIT   = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  mode_e mode_i,
  input  logic  a_i,
  input  logic  b_i,
  output logic  q_o
);
  logic q_q, q_d, both_d;
  always_comb begin
    both_d = SR_POLICY == POL_SET ? 1'b1 : SR_POLICY == POL_RESET ? 1'b0 : q_q;
    q_d = !en_i                  ? q_q :
          mode_i == MODE_D       ? a_i :
          mode_i == MODE_T       ? q_q ^ a_i :
          a_i && !b_i            ? 1'b1 :
          !a_i && b_i            ? 1'b0 :
          !a_i                   ? q_q :
          mode_i == MODE_JK      ? ~q_q : both_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= RST_BIT;
    else        q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH mode-selectable flip-flops with SR-conflict flag and counter
module multimode_ff_bank
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = POL_HOLD,
  parameter int               CNT_W     = 8
) (
  input logic                clk,
  input logic                rst_n,
  multimode_ff_bank_if.slave bus
);
  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic             conflict, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign mode = mode_e'(bus.mode);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(.SR_POLICY(SR_POLICY), .RST_BIT(RESET_VAL[i])) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (bus.en),
      .mode_i(mode),
      .a_i   (bus.a[i]),
      .b_i   (bus.b[i]),
      .q_o   (q[i])
    );
  end
  // a conflict beats a simultaneous clear, restarting the count at one
  always_comb begin
    conflict = bus.en && mode == MODE_SR && |(bus.a & bus.b);
    err_d    = conflict ? 1'b1 : bus.clr_err ? 1'b0 : err_q;
    cnt_d    = conflict ? (bus.clr_err ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1)) :
               bus.clr_err ? '0 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign bus.q            = q;
  assign bus.qbar         = ~q;
  assign bus.err          = err_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// tb_multimode_ff_bank: scoreboard bench driving hold/set/reset-policy banks and a 2-bit-counter bank in lockstep
module tb_multimode_ff_bank;
  typedef struct {
    string      nm;
    logic [7:0] qh, qs, qr, c8;
    logic       er;
    logic [1:0] c2;
  } exp_t;
  logic       clk = 0, rst_n = 0, en = 0, clr = 0;
  logic [1:0] mode = 0;
  logic [7:0] a = 0, b = 0;
  exp_t       sb[$];
  int         n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  multimode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) b0 (), b1 (), b2 ();
  multimode_ff_bank_if #(.WIDTH(8), .CNT_W(2)) b3 ();
  assign b0.en = en;   assign b0.mode = mode; assign b0.a = a; assign b0.b = b; assign b0.clr_err = clr;
  assign b1.en = en;   assign b1.mode = mode; assign b1.a = a; assign b1.b = b; assign b1.clr_err = clr;
  assign b2.en = en;   assign b2.mode = mode; assign b2.a = a; assign b2.b = b; assign b2.clr_err = clr;
  assign b3.en = en;   assign b3.mode = mode; assign b3.a = a; assign b3.b = b; assign b3.clr_err = clr;
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_POLICY(0), .CNT_W(8)) u_hold  (.clk(clk), .rst_n(rst_n), .bus(b0));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_POLICY(1), .CNT_W(8)) u_set   (.clk(clk), .rst_n(rst_n), .bus(b1));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_POLICY(2), .CNT_W(8)) u_reset (.clk(clk), .rst_n(rst_n), .bus(b2));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_POLICY(0), .CNT_W(2)) u_sat   (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic chk(string nm, string what, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", nm, what, got, want);
    end
  endtask

  task automatic step(string nm, logic e, logic [1:0] m, logic [7:0] aa, logic [7:0] bb, logic c,
                      logic [7:0] qh, logic [7:0] qs, logic [7:0] qr, logic er, logic [7:0] c8, logic [1:0] c2);
    exp_t x;
    x.nm = nm; x.qh = qh; x.qs = qs; x.qr = qr; x.er = er; x.c8 = c8; x.c2 = c2;
    en = e; mode = m; a = aa; b = bb; clr = c;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(string nm);
    chk(nm, "q_hold", b0.q, 8'h00);      chk(nm, "q_set", b1.q, 8'h00);
    chk(nm, "q_reset", b2.q, 8'h00);     chk(nm, "q_sat", b3.q, 8'h00);
    chk(nm, "qbar_hold", b0.qbar, 8'hFF);
    chk(nm, "err_hold", 8'(b0.err), 8'h00); chk(nm, "err_sat", 8'(b3.err), 8'h00);
    chk(nm, "cnt_hold", b0.conflict_cnt, 8'h00); chk(nm, "cnt_sat", 8'(b3.conflict_cnt), 8'h00);
  endtask

  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk(x.nm, "q_hold", b0.q, x.qh);
      chk(x.nm, "q_set", b1.q, x.qs);
      chk(x.nm, "q_reset", b2.q, x.qr);
      chk(x.nm, "q_sat", b3.q, x.qh);
      chk(x.nm, "qbar_hold", b0.qbar, ~x.qh);
      chk(x.nm, "qbar_set", b1.qbar, ~x.qs);
      chk(x.nm, "qbar_reset", b2.qbar, ~x.qr);
      chk(x.nm, "err_hold", 8'(b0.err), 8'(x.er));
      chk(x.nm, "err_set", 8'(b1.err), 8'(x.er));
      chk(x.nm, "err_reset", 8'(b2.err), 8'(x.er));
      chk(x.nm, "err_sat", 8'(b3.err), 8'(x.er));
      chk(x.nm, "cnt_hold", b0.conflict_cnt, x.c8);
      chk(x.nm, "cnt_set", b1.conflict_cnt, x.c8);
      chk(x.nm, "cnt_reset", b2.conflict_cnt, x.c8);
      chk(x.nm, "cnt_sat", 8'(b3.conflict_cnt), 8'(x.c2));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;
    step("sr_set",    1, 2'd0, 8'hFF, 8'h00, 0, 8'hFF, 8'hFF, 8'hFF, 0, 8'd0, 2'd0);
    step("sr_rst",    1, 2'd0, 8'h00, 8'h0F, 0, 8'hF0, 8'hF0, 8'hF0, 0, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      step("sr_hold", 1, 2'd0, 8'h00, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 0, 8'd0, 2'd0);
    step("sr_conf",   1, 2'd0, 8'h81, 8'h81, 0, 8'hF0, 8'hF1, 8'h70, 1, 8'd1, 2'd1);
    step("jk_tog",    1, 2'd1, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0E, 8'h8F, 1, 8'd1, 2'd1);
    step("t_mode",    1, 2'd3, 8'h03, 8'h00, 0, 8'h0C, 8'h0D, 8'h8C, 1, 8'd1, 2'd1);
    step("d_mode",    1, 2'd2, 8'h5A, 8'h00, 0, 8'h5A, 8'h5A, 8'h5A, 1, 8'd1, 2'd1);
    for (int i = 0; i < 5; i++)
      step("sat",     1, 2'd0, 8'h01, 8'h01, 0, 8'h5A, 8'h5B, 8'h5A, 1, 8'(2 + i), (i >= 1) ? 2'd3 : 2'd2);
    step("clr_conf",  1, 2'd0, 8'h01, 8'h01, 1, 8'h5A, 8'h5B, 8'h5A, 1, 8'd1, 2'd1);
    step("clr_only",  1, 2'd0, 8'h00, 8'h00, 1, 8'h5A, 8'h5B, 8'h5A, 0, 8'd0, 2'd0);
    step("conf80",    1, 2'd0, 8'h80, 8'h80, 0, 8'h5A, 8'hDB, 8'h5A, 1, 8'd1, 2'd1);
    for (int i = 0; i < 4; i++)
      step("en_off",  0, 2'(i), 8'hFF, 8'hFF, 0, 8'h5A, 8'hDB, 8'h5A, 1, 8'd1, 2'd1);
    step("en_off_clr",0, 2'd0, 8'hFF, 8'hFF, 1, 8'h5A, 8'hDB, 8'h5A, 0, 8'd0, 2'd0);
    step("t_ff",      1, 2'd3, 8'hFF, 8'h00, 0, 8'hA5, 8'h24, 8'hA5, 0, 8'd0, 2'd0);
    step("t_ff2",     1, 2'd3, 8'hFF, 8'h00, 0, 8'h5A, 8'hDB, 8'h5A, 0, 8'd0, 2'd0);
    #2 rst_n = 0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1;
    step("t_resume",  1, 2'd3, 8'hFF, 8'h00, 0, 8'hFF, 8'hFF, 8'hFF, 0, 8'd0, 2'd0);
    step("t_resume2", 1, 2'd3, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'd0, 2'd0);
    en = 0;
    repeat (2) @(negedge clk);
    chk("drain", "pending", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
